// File: rtl/init_table_rom.sv
// Parametrised lookup table self-loaded with BASE + i*STEP after every reset or
// on request, with a registered ready/valid read port and runtime entry overwrite.
module init_table_rom #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BASE   = 0,
    parameter int STEP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              busy,
    output logic              rd_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] BASE_L   = DATA_W'(BASE);
    localparam logic [DATA_W-1:0] STEP_L   = DATA_W'(STEP);

    // Modular arithmetic: truncating each operand to DATA_W bits keeps the result exact mod 2**DATA_W
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] i);
        return BASE_L + DATA_W'(i) * STEP_L;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_err_q, rd_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Next-state, read-port and table-write decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        mem_waddr  = idx_q;
        mem_wdata  = pattern(idx_q);
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    // Read samples the table before this edge's write lands
                    if (rd_req) begin
                        rd_valid_d = 1'b1;
                        if (in_range(rd_addr)) begin
                            rd_data_d = mem_q[rd_addr];
                            rd_err_d  = 1'b0;
                        end else begin
                            rd_data_d = {DATA_W{1'b0}};
                            rd_err_d  = 1'b1;
                        end
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                    if (wr_en && in_range(wr_addr)) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr;
                        mem_wdata = wr_data;
                    end else begin
                        mem_we = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            idx_q      <= {ADDR_W{1'b0}};
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Table storage; contents survive reset and are reloaded by the init engine
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy     = busy_q;
    assign rd_ready = ~busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_init_table_rom.sv
// Scoreboard bench: three table configurations share one stimulus stream and are
// checked against a per-configuration behavioural model of the lookup table.
module tb_init_table_rom;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;

    logic       busy_s     [3];
    logic       rd_ready_s [3];
    logic       rd_valid_s [3];
    logic       rd_err_s   [3];
    logic [3:0] rd_data_s  [3];

    always #5 clk = ~clk;

    init_table_rom #(.DATA_W(4), .DEPTH(8), .ADDR_W(3), .BASE(0), .STEP(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_s[0]), .rd_ready(rd_ready_s[0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_s[0]), .rd_data(rd_data_s[0]),
        .rd_err(rd_err_s[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    init_table_rom #(.DATA_W(4), .DEPTH(8), .ADDR_W(3), .BASE(3), .STEP(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_s[1]), .rd_ready(rd_ready_s[1]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_s[1]), .rd_data(rd_data_s[1]),
        .rd_err(rd_err_s[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    init_table_rom #(.DATA_W(4), .DEPTH(6), .ADDR_W(3), .BASE(0), .STEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_s[2]), .rd_ready(rd_ready_s[2]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_s[2]), .rd_data(rd_data_s[2]),
        .rd_err(rd_err_s[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    int         depth_a [3] = '{8, 8, 6};
    int         base_a  [3] = '{0, 3, 0};
    int         step_a  [3] = '{2, 5, 2};
    int         busy_cnt [3];
    logic [3:0] mem_m [3][8];
    logic [3:0] last_data [3];
    logic [4:0] exp_q [3][$];
    bit         started = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    function automatic logic [3:0] pat(input int d, input int i);
        return 4'((base_a[d] + i * step_a[d]) % 16);
    endfunction

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Reference model: table contents, init countdown, read-before-write
    initial begin
        for (int d = 0; d < 3; d++) begin
            busy_cnt[d]  = depth_a[d];
            last_data[d] = 4'd0;
            for (int i = 0; i < 8; i++) mem_m[d][i] = 4'd0;
        end
        forever begin
            @(posedge clk);
            started = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    busy_cnt[d]  = depth_a[d];
                    last_data[d] = 4'd0;
                end else if (busy_cnt[d] > 0) begin
                    busy_cnt[d]--;
                    if (busy_cnt[d] == 0)
                        for (int i = 0; i < depth_a[d]; i++) mem_m[d][i] = pat(d, i);
                end else if (init_req) begin
                    busy_cnt[d] = depth_a[d];
                end else begin
                    if (rd_req) begin
                        if (int'(rd_addr) < depth_a[d]) exp_q[d].push_back({1'b0, mem_m[d][rd_addr]});
                        else exp_q[d].push_back({1'b1, 4'h0});
                    end
                    if (wr_en && int'(wr_addr) < depth_a[d]) mem_m[d][wr_addr] = wr_data;
                end
            end
        end
    end

    // Monitor: compares every cycle, popping an expectation whenever one is due
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int d = 0; d < 3; d++) begin
                    chk("busy", d, 8'(busy_s[d]), 8'(busy_cnt[d] > 0));
                    chk("rd_ready", d, 8'(rd_ready_s[d]), 8'(busy_cnt[d] == 0));
                    if (rd_valid_s[d] === 1'b1) begin
                        if (exp_q[d].size() == 0) begin
                            chk("spurious_valid", d, 8'(rd_valid_s[d]), 8'd0);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk("rd_data", d, 8'(rd_data_s[d]), 8'(e[3:0]));
                            chk("rd_err", d, 8'(rd_err_s[d]), 8'(e[4]));
                            last_data[d] = e[3:0];
                        end
                    end else begin
                        if (exp_q[d].size() != 0) begin
                            e = exp_q[d].pop_front();
                            chk("missing_valid", d, 8'(rd_valid_s[d]), 8'd1);
                        end
                        chk("rd_data_hold", d, 8'(rd_data_s[d]), 8'(last_data[d]));
                        chk("rd_err_idle", d, 8'(rd_err_s[d]), 8'd0);
                    end
                end
            end
        end
    end

    task automatic drive(input bit rr, input logic [2:0] ra, input bit we,
                         input logic [2:0] wa, input logic [3:0] wd, input bit ir);
        @(negedge clk);
        rd_req   = rr;
        rd_addr  = ra;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        init_req = ir;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0, 3'd0, 4'd0, 1'b0);
        idle(2);
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(10);
        read_all();
        // Overwrite, then same-cycle read/write collision
        drive(1'b0, 3'd0, 1'b1, 3'd5, 4'hF, 1'b0);
        drive(1'b1, 3'd5, 1'b0, 3'd0, 4'd0, 1'b0);
        drive(1'b1, 3'd3, 1'b1, 3'd3, 4'h1, 1'b0);
        drive(1'b1, 3'd3, 1'b0, 3'd0, 4'd0, 1'b0);
        // Out-of-range read and write
        drive(1'b1, 3'd7, 1'b0, 3'd0, 4'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 3'd6, 4'd9, 1'b0);
        read_all();
        // Re-init colliding with a read request
        drive(1'b0, 3'd0, 1'b1, 3'd2, 4'h9, 1'b0);
        drive(1'b1, 3'd2, 1'b0, 3'd0, 4'd0, 1'b1);
        idle(10);
        read_all();
        // Reset pulse in the middle of an init run
        drive(1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1);
        idle(3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(10);
        read_all();
        // Randomised traffic with rare init requests and reset pulses
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 4'($urandom_range(15)), $urandom_range(39) == 0);
            rst_n = ($urandom_range(99) != 0);
        end
        rst_n = 1'b1;
        idle(12);
        read_all();
        idle(2);
        for (int d = 0; d < 3; d++) chk("queue_empty", d, 8'(exp_q[d].size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/init_table_rom.md
Name: init_table_rom

Overview:
- Parametrised lookup table whose contents are loaded with an arithmetic pattern, entry i = BASE + i*STEP, after every reset and on request.
- Generalises the fixed 8x4 even-number table to any width and depth.
- Adds a sequential init engine, a registered read port with ready/valid signalling, runtime overwrite of entries and out-of-range detection.
- Sits as a coefficient/constant source feeding datapath blocks.

Parameters:
DATA_W, 4, entry width in bits
DEPTH, 8, number of entries (>=2)
ADDR_W, 3, address width; DEPTH <= 2**ADDR_W required
BASE, 0, value of entry 0
STEP, 2, increment between consecutive entries

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
init_req  in  1  pulse: reload the whole table with the pattern
busy  out  1  high while the init engine runs
rd_ready  out  1  equals ~busy; read port accepts requests
rd_req  in  1  read request, accepted when rd_req & rd_ready
rd_addr  in  ADDR_W  read address
rd_valid  out  1  one-cycle pulse, read result valid
rd_data  out  DATA_W  read result, held until next rd_valid
rd_err  out  1  pulses with rd_valid when rd_addr >= DEPTH
wr_en  in  1  overwrite one entry (IDLE only)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: the FSM goes to INIT with idx=0.
  - Output reset values: busy=1, rd_valid=0, rd_err=0, rd_data=0.
  - Table contents are not cleared by reset itself; the init engine loads them.
- FSM has two states, INIT and IDLE.
- INIT:
  - Each cycle, write table[idx] = (BASE + idx*STEP) mod 2**DATA_W, then idx++.
  - The multiply is truncated to DATA_W bits.
  - At the edge that writes idx=DEPTH-1, go to IDLE.
  - Counting edges from the first rising edge with rst_n=1: entry k is written at edge k+1. busy falls after edge DEPTH, so the table takes DEPTH cycles.
  - rd_req, wr_en and init_req are ignored in INIT. No rd_valid is produced.
- IDLE:
  - busy=0.
  - init_req=1 moves the FSM to INIT with idx=0 at the next edge.
  - init_req has priority over rd_req and wr_en in the same cycle; both are dropped.
- Read:
  - Accepted at edge E when in IDLE with rd_req=1.
  - rd_valid=1 during the cycle after E; latency is 1.
  - In-range address: rd_data = table[rd_addr] as it was before edge E, rd_err=0.
  - rd_addr >= DEPTH: rd_data=0, rd_err=1.
  - Back-to-back reads, one per cycle, are supported, giving continuous rd_valid.
  - rd_data is held when rd_valid=0.
- Write:
  - In IDLE, wr_en=1 writes table[wr_addr]=wr_data at the edge.
  - wr_addr >= DEPTH is silently ignored.
- Read and write to the same address in the same cycle: read-before-write, so rd_data returns the old value and the next read returns the new one.
- Reset mid-operation: any cycle with rst_n=0 aborts the INIT or read in progress.
  - The next rd_valid is suppressed.
  - Init restarts from idx=0.
  - Entries written before the abort are simply overwritten.
- No combinational path from inputs to outputs.

Test Plan:
- Defaults, release reset:
  - Required: busy=1 for exactly 8 cycles, then 0.
  - Read addr 0..7 back-to-back, 8 cycles of continuous rd_valid; required rd_data = 0,2,4,6,8,10,12,14 with rd_err=0 throughout.
- Wrap-around, DATA_W=4, BASE=3, STEP=5:
  - Required: entries read 3,8,13,2,7,12,1,6.
- Overwrite and collision:
  - Write addr 5 = 4'hF; read addr 5 → 15.
  - Same cycle, read addr 3 and write addr 3 = 4'h1 → rd_data=6; next read addr 3 → 1.
- Out of range, DEPTH=6, ADDR_W=3:
  - Read addr 7 → rd_valid=1, rd_err=1, rd_data=0.
  - Write addr 6 = 9 → no effect; all entries remain 0,2,4,6,8,10.
- Re-init:
  - After overwriting addr 2 = 4'h9, pulse init_req together with rd_req.
  - Required: no rd_valid, busy=1 for 8 cycles, rd_ready=0 throughout; afterwards addr 2 reads 4.
- Mid-init reset:
  - Assert rst_n=0 for 1 cycle at init cycle 4.
  - Required: busy stays 1 for a full 8 cycles after release, rd_valid stays 0, and all entries read correct afterwards.
